// File: rtl/vec_pkg.sv
// Shared constants and FSM state type for the vector assembler and
// the downstream popcount stage.
package vec_pkg;

    localparam int VEC_WIDTH    = 1100;
    localparam int WORD_WIDTH   = 32;
    localparam int BEATS        = (VEC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int POPCNT_WIDTH = $clog2(VEC_WIDTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/vec_assembler.sv
// Collects BEATS input words into one VEC_WIDTH vector and hands it to the
// popcount stage with a valid/ready handshake; beat k lands at
// vec[k*WORD_WIDTH +: WORD_WIDTH], padding bits of the final beat dropped.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   word            input beat data
//   word_valid      input beat valid
//   word_last       producer's end-of-vector marker
//   this_ready      beat can be accepted this cycle
//   vec, out_valid  assembled vector and its valid
//   next_ready      downstream accepts vec
//   err_len         sticky framing error flag
//
// Build option VEC_ASM_LAST_CHECK_EN: when defined, word_last is checked
// against the beat position; otherwise word_last is ignored, err_len = 0.
module vec_assembler #(
    parameter int VEC_WIDTH  = vec_pkg::VEC_WIDTH,
    parameter int WORD_WIDTH = vec_pkg::WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic                  word_valid,
    input  logic                  word_last,
    output logic                  this_ready,
    output logic [VEC_WIDTH-1:0]  vec,
    output logic                  out_valid,
    input  logic                  next_ready,
    output logic                  err_len
);

    import vec_pkg::state_e;
    import vec_pkg::FILL;
    import vec_pkg::HOLD;

    localparam int BEATS  = (VEC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_W = VEC_WIDTH - (BEATS - 1) * WORD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VEC_WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]     wr_idx;
    logic [BEATS-1:0]     wr_en;
    logic                 accept;
    logic                 deliver;
    logic                 is_last;
    logic                 drop;

    assign out_valid  = (state_q == HOLD);
    assign this_ready = (state_q == FILL) || next_ready;
    assign accept     = word_valid && this_ready;
    assign deliver    = out_valid && next_ready;
    assign vec        = vec_q;

    // A beat taken while holding is beat 0 of the next vector.
    assign wr_idx  = (state_q == HOLD) ? '0 : cnt_q;
    assign is_last = (wr_idx == LAST_IDX);

    for (genvar k = 0; k < BEATS; k++) begin : g_we
        assign wr_en[k] = accept && (wr_idx == CNT_W'(k));
    end

    for (genvar k = 0; k < BEATS - 1; k++) begin : g_beat
        assign vec_d[k*WORD_WIDTH +: WORD_WIDTH] =
            wr_en[k] ? word : vec_q[k*WORD_WIDTH +: WORD_WIDTH];
    end

    // Final beat keeps only the bits that fit inside the vector.
    assign vec_d[VEC_WIDTH-1 -: LAST_W] =
        wr_en[BEATS-1] ? word[LAST_W-1:0] : vec_q[VEC_WIDTH-1 -: LAST_W];

`ifdef VEC_ASM_LAST_CHECK_EN
    logic err_q, err_d;

    // Early word_last abandons the partial vector; a missing one on the
    // final beat is flagged but the vector still completes.
    assign drop = accept && word_last && !is_last;

    always_comb begin
        err_d = err_q;
        if (accept && (word_last != is_last)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_len = err_q;
`else
    logic unused_word_last;

    assign unused_word_last = word_last;
    assign drop             = 1'b0;
    assign err_len          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            state_d = FILL;
            cnt_d   = '0;
        end
        if (accept) begin
            if (drop) begin
                state_d = FILL;
                cnt_d   = '0;
            end else if (is_last) begin
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                state_d = FILL;
                cnt_d   = wr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_vec_assembler.sv
// Scoreboard bench for vec_assembler: directed framing/stall/reset cases
// plus randomized traffic with random gaps and downstream backpressure.
module tb_vec_assembler;

    localparam int VW = 1100;
    localparam int WW = 32;
    localparam int NB = 35;

    typedef logic [WW-1:0] beats_t [NB];
    typedef struct {
        logic [VW-1:0] v;
        int            pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] word;
    logic          word_valid;
    logic          word_last;
    logic          this_ready;
    logic [VW-1:0] vec;
    logic          out_valid;
    logic          next_ready;
    logic          err_len;

    int   passed = 0;
    int   total  = 0;
    exp_t q[$];
    bit   rand_bp = 0;
    bit   gap_en  = 0;

    always #5 clk = ~clk;

    vec_assembler #(
        .VEC_WIDTH (VW),
        .WORD_WIDTH(WW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .word      (word),
        .word_valid(word_valid),
        .word_last (word_last),
        .this_ready(this_ready),
        .vec       (vec),
        .out_valid (out_valid),
        .next_ready(next_ready),
        .err_len   (err_len)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void chk_vec(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
        int first;
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            first = -1;
            for (int i = VW - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: vec differs first at bit %0d got %b expected %b (popcount got %0d expected %0d)",
                     name, first, act[first], exp[first], $countones(act), $countones(exp));
        end
    endfunction

    // Reference: beat k bit j belongs at vector bit k*WW+j if it fits.
    function automatic exp_t model(input beats_t b);
        exp_t e;
        int   idx;
        e.v  = '0;
        e.pc = 0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < WW; j++) begin
                idx = k * WW + j;
                if (idx < VW) begin
                    e.v[idx] = b[k][j];
                    e.pc += int'(b[k][j]);
                end
            end
        end
        return e;
    endfunction

    task automatic send_beats(input beats_t b, input int from, input int upto, input int last_at);
        bit rdy;
        int t;
        for (int k = from; k <= upto; k++) begin
            if (gap_en) begin
                word_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            word       = b[k];
            word_valid = 1'b1;
            word_last  = (k == last_at);
            t = 0;
            do begin
                @(negedge clk);
                rdy = this_ready;
                @(posedge clk);
                #1;
                t++;
            end while (!rdy && t < 300);
            if (!rdy) begin
                total++;
                $display("FAIL accept_timeout: beat %0d not accepted after %0d cycles", k, t);
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic send_vec(input beats_t b);
        q.push_back(model(b));
        send_beats(b, 0, NB - 1, NB - 1);
    endtask

    // Monitor: pops the scoreboard on every delivery and checks stalls.
    logic [VW-1:0] prev_vec;
    bit            prev_stall = 0;
    exp_t          got;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk_vec("stall_vec_stable", vec, prev_vec);
                chk("stall_valid_held", out_valid, 1);
            end
            if (out_valid && !next_ready) chk("stall_no_ready", this_ready, 0);
            if (out_valid && next_ready) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_vec: delivery with empty scoreboard, popcount %0d",
                             $countones(vec));
                end else begin
                    got = q.pop_front();
                    chk_vec("deliver_vec", vec, got.v);
                    chk("deliver_popcount", $countones(vec), got.pc);
                end
            end
            prev_stall = out_valid && !next_ready;
            prev_vec   = vec;
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            next_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        beats_t a, b;
        exp_t   ea;
        int     t;

        rst        = 1'b1;
        word       = '0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        next_ready = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_this_ready", this_ready, 1);
        chk("rst_vec_zero", $countones(vec), 0);
        chk("rst_err_len", err_len, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", this_ready, 1);
        @(posedge clk);
        #1;

        // all ones, one-cycle latency
        for (int k = 0; k < NB; k++) a[k] = '1;
        send_vec(a);
        @(negedge clk);
        chk("s1_latency", out_valid, 1);
        chk("s1_popcount", $countones(vec), 1100);
        @(negedge clk);
        chk("s1_one_cycle", out_valid, 0);
        @(posedge clk);
        #1;

        // back-to-back vectors, no bubble
        for (int k = 0; k < NB; k++) a[k] = 32'h1;
        for (int k = 0; k < NB; k++) b[k] = 32'hFFFF_FFFF;
        q.push_back(model(a));
        send_beats(a, 0, NB - 1, NB - 1);
        q.push_back(model(b));
        word       = b[0];
        word_valid = 1'b1;
        @(negedge clk);
        chk("s2_pc_a", $countones(vec), 35);
        chk("s2_overlap_valid", out_valid, 1);
        chk("s2_overlap_ready", this_ready, 1);
        @(posedge clk);
        #1;
        chk("s2_b_started", out_valid, 0);
        send_beats(b, 1, NB - 1, NB - 1);
        @(negedge clk);
        chk("s2_pc_b", $countones(vec), 1100);
        @(posedge clk);
        #1;

        // 5-cycle stall with word_valid held
        for (int k = 0; k < NB; k++) a[k] = $urandom;
        for (int k = 0; k < NB; k++) b[k] = $urandom;
        next_ready = 1'b0;
        ea = model(a);
        send_vec(a);
        word       = b[0];
        word_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("s3_ready_low", this_ready, 0);
            chk_vec("s3_vec_held", vec, ea.v);
        end
        @(posedge clk);
        #1;
        next_ready = 1'b1;
        q.push_back(model(b));
        @(negedge clk);
        chk("s3_release_ready", this_ready, 1);
        @(posedge clk);
        #1;
        chk("s3_b_started", out_valid, 0);
        send_beats(b, 1, NB - 1, NB - 1);
        @(posedge clk);
        #1;

        // framing
        for (int k = 0; k < NB; k++) a[k] = $urandom;
        for (int k = 0; k < NB; k++) b[k] = $urandom;
`ifdef VEC_ASM_LAST_CHECK_EN
        send_beats(a, 0, 10, 10);
        @(negedge clk);
        chk("s4_err_set", err_len, 1);
        chk("s4_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send_vec(b);
        @(negedge clk);
        chk("s4_err_sticky", err_len, 1);
`else
        q.push_back(model(a));
        send_beats(a, 0, NB - 1, 10);
        @(negedge clk);
        chk("s4_last_ignored", out_valid, 1);
        chk("s4_err_tied", err_len, 0);
`endif
        @(posedge clk);
        #1;

        // reset mid-vector
        for (int k = 0; k < NB; k++) a[k] = $urandom;
        for (int k = 0; k < NB; k++) b[k] = $urandom;
        send_beats(a, 0, 20, NB - 1);
        rst = 1'b1;
        #1;
        chk("s5_rst_valid", out_valid, 0);
        chk("s5_rst_vec", $countones(vec), 0);
        chk("s5_rst_err", err_len, 0);
        #2;
        rst = 1'b0;
        send_vec(b);
        @(negedge clk);
        chk("s5_vec_done", out_valid, 1);
        @(posedge clk);
        #1;

        // padding bits dropped
        for (int k = 0; k < NB; k++) a[k] = '0;
        a[NB-1] = 32'hFFFF_FFFF;
        send_vec(a);
        @(negedge clk);
        chk("s6_pad_popcount", $countones(vec), 12);
        @(posedge clk);
        #1;

        // randomized traffic
        gap_en  = 1;
        rand_bp = 1;
        repeat (20) begin
            for (int k = 0; k < NB; k++) a[k] = $urandom;
            send_vec(a);
        end
        rand_bp = 0;
        gap_en  = 0;
        repeat (2) @(posedge clk);
        #1;
        next_ready = 1'b1;
        t = 0;
        while (q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
